// File: rtl/sample_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_sequencer_pkg                                         |
// | Description : Shared types and codes for the per-sample SPI scheduler:     |
// |               sequencer state encoding, SPI owner codes, DAC channel codes.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sample_sequencer_pkg;

  // Sequencer states: a start state is always followed by its wait state.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_AMP   = 4'd1,
    ST_AMP_W = 4'd2,
    ST_ADC   = 4'd3,
    ST_ADC_W = 4'd4,
    ST_DAC_A = 4'd5,
    ST_DA_W  = 4'd6,
    ST_DAC_B = 4'd7,
    ST_DB_W  = 4'd8
  } seq_state_e;

  // MOSI / chip-select ownership codes.
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_AMP  = 2'b01;
  localparam logic [1:0] OWN_ADC  = 2'b10;
  localparam logic [1:0] OWN_DAC  = 2'b11;

  // DAC channel select codes.
  localparam logic DAC_CH_A = 1'b0;
  localparam logic DAC_CH_B = 1'b1;

  // True in the states that wait for a driver's done pulse (timeout applies).
  function automatic logic is_wait_state(input seq_state_e s);
    return (s == ST_AMP_W) || (s == ST_ADC_W) || (s == ST_DA_W) || (s == ST_DB_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_sequencer_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_sequencer_tick_counter                                |
// | Description : Modulo-MODULO counter advanced by a tick strobe when enabled.|
// |               wrap is asserted combinationally in the cycle whose tick     |
// |               completes a full count (terminal count), then count -> 0.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sample_sequencer_tick_counter #(
  parameter int CNT_W  = 8,
  parameter int MODULO = 40
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic wrap
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MODULO - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             step;

  // Next count: clear wins, otherwise count ticks and fold back at the terminal value.
  always_comb begin
    step    = en & tick & ~clr;
    wrap    = step & (count_q == C_LAST);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + C_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sample_sequencer                                             |
// | Description : Per-sample scheduler for the shared SPI bus. Generates the   |
// |               sample period, sequences preamp / ADC / DAC A / DAC B starts,|
// |               grants MOSI ownership and queues gain-change requests.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int PERIOD_TICKS  = 40,
  parameter int TIMEOUT_TICKS = 64,
  parameter int CNT_W         = 8
) (
  input  logic       CLK_50M,
  input  logic       RESET,
  input  logic       sck_tick,
  input  logic       enable,
  input  logic       gain_req,
  input  logic [7:0] gain_value,
  input  logic       amp_done,
  input  logic       adc_done,
  input  logic       dac_done,
  output logic       amp_start,
  output logic [7:0] amp_gain,
  output logic       adc_start,
  output logic       dac_start,
  output logic       dac_sel,
  output logic [1:0] spi_owner,
  output logic       sample_strobe,
  output logic       overrun,
  output logic       fault
);

  seq_state_e state_q, state_d;
  logic       amp_start_q, amp_start_d;
  logic [7:0] amp_gain_q, amp_gain_d;
  logic       adc_start_q, adc_start_d;
  logic       dac_start_q, dac_start_d;
  logic       dac_sel_q, dac_sel_d;
  logic [1:0] spi_owner_q, spi_owner_d;
  logic       overrun_q, overrun_d;
  logic       fault_q, fault_d;
  logic [7:0] gain_pend_q, gain_pend_d;
  logic       pend_q, pend_d;
  logic       frame_tick_q, frame_tick_d;

  logic       period_wrap;
  logic       timeout;
  logic       in_wait;
  logic       adc_accept;

  assign in_wait = is_wait_state(state_q);

  // Sample-period counter; frozen while disabled so no new frame is requested.
  sample_sequencer_tick_counter #(
    .CNT_W  (CNT_W),
    .MODULO (PERIOD_TICKS)
  ) u_period_cnt (
    .clk  (CLK_50M),
    .rst  (RESET),
    .clr  (1'b0),
    .en   (enable),
    .tick (sck_tick),
    .wrap (period_wrap)
  );

  // Driver watchdog; held at zero outside wait states so every wait starts fresh.
  sample_sequencer_tick_counter #(
    .CNT_W  (CNT_W),
    .MODULO (TIMEOUT_TICKS)
  ) u_timeout_cnt (
    .clk  (CLK_50M),
    .rst  (RESET),
    .clr  (~in_wait),
    .en   (in_wait),
    .tick (sck_tick),
    .wrap (timeout)
  );

  // Next-state and output decode; outputs are computed on the transition into a
  // state so their registered values line up with that state. The sample strobe
  // is the one exception: it must coincide with adc_done so the datapath latches
  // the ADC word while it is still valid.
  always_comb begin
    state_d      = state_q;
    amp_start_d  = 1'b0;
    adc_start_d  = 1'b0;
    dac_start_d  = 1'b0;
    amp_gain_d   = amp_gain_q;
    dac_sel_d    = dac_sel_q;
    spi_owner_d  = spi_owner_q;
    fault_d      = fault_q;
    gain_pend_d  = gain_pend_q;
    pend_d       = pend_q;
    adc_accept   = 1'b0;
    frame_tick_d = period_wrap;
    // A frame boundary that finds the sequence busy is dropped and flagged.
    overrun_d    = overrun_q | (frame_tick_q & (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (frame_tick_q && enable) begin
          if (pend_q) begin
            state_d     = ST_AMP;
            amp_start_d = 1'b1;
            amp_gain_d  = gain_pend_q;
            spi_owner_d = OWN_AMP;
            pend_d      = 1'b0;
          end else begin
            state_d     = ST_ADC;
            adc_start_d = 1'b1;
            spi_owner_d = OWN_ADC;
          end
        end
      end
      ST_AMP: state_d = ST_AMP_W;
      ST_AMP_W: begin
        if (amp_done) begin
          state_d     = ST_ADC;
          adc_start_d = 1'b1;
          spi_owner_d = OWN_ADC;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          spi_owner_d = OWN_NONE;
          fault_d     = 1'b1;
        end
      end
      ST_ADC: state_d = ST_ADC_W;
      ST_ADC_W: begin
        if (adc_done) begin
          adc_accept  = 1'b1;
          state_d     = ST_DAC_A;
          dac_start_d = 1'b1;
          dac_sel_d   = DAC_CH_A;
          spi_owner_d = OWN_DAC;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          spi_owner_d = OWN_NONE;
          fault_d     = 1'b1;
        end
      end
      ST_DAC_A: state_d = ST_DA_W;
      ST_DA_W: begin
        if (dac_done) begin
          state_d     = ST_DAC_B;
          dac_start_d = 1'b1;
          dac_sel_d   = DAC_CH_B;
        end else if (timeout) begin
          state_d     = ST_IDLE;
          spi_owner_d = OWN_NONE;
          fault_d     = 1'b1;
        end
      end
      ST_DAC_B: state_d = ST_DB_W;
      ST_DB_W: begin
        if (dac_done || timeout) begin
          state_d     = ST_IDLE;
          spi_owner_d = OWN_NONE;
          fault_d     = fault_q | ~dac_done;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        spi_owner_d = OWN_NONE;
      end
    endcase

    // Gain capture is last so a request in the consuming cycle stays queued.
    if (gain_req) begin
      gain_pend_d = gain_value;
      pend_d      = 1'b1;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK_50M or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      amp_start_q  <= 1'b0;
      amp_gain_q   <= 8'h00;
      adc_start_q  <= 1'b0;
      dac_start_q  <= 1'b0;
      dac_sel_q    <= DAC_CH_A;
      spi_owner_q  <= OWN_NONE;
      overrun_q    <= 1'b0;
      fault_q      <= 1'b0;
      gain_pend_q  <= 8'h00;
      pend_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      amp_start_q  <= amp_start_d;
      amp_gain_q   <= amp_gain_d;
      adc_start_q  <= adc_start_d;
      dac_start_q  <= dac_start_d;
      dac_sel_q    <= dac_sel_d;
      spi_owner_q  <= spi_owner_d;
      overrun_q    <= overrun_d;
      fault_q      <= fault_d;
      gain_pend_q  <= gain_pend_d;
      pend_q       <= pend_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign amp_start     = amp_start_q;
  assign amp_gain      = amp_gain_q;
  assign adc_start     = adc_start_q;
  assign dac_start     = dac_start_q;
  assign dac_sel       = dac_sel_q;
  assign spi_owner     = spi_owner_q;
  assign sample_strobe = adc_accept;
  assign overrun       = overrun_q;
  assign fault         = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sample_sequencer                                          |
// | Description : Directed self-checking bench for sample_sequencer: nominal   |
// |               frame, gain queueing, overrun, timeout, stray done, reset.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_sample_sequencer;

  localparam int PERIOD = 40;

  logic       CLK_50M = 1'b0;
  logic       RESET = 1'b0;
  logic       sck_tick = 1'b0;
  logic       enable = 1'b0;
  logic       gain_req = 1'b0;
  logic [7:0] gain_value = 8'h00;
  logic       amp_done = 1'b0;
  logic       adc_done = 1'b0;
  logic       dac_done = 1'b0;
  logic       amp_start;
  logic [7:0] amp_gain;
  logic       adc_start;
  logic       dac_start;
  logic       dac_sel;
  logic [1:0] spi_owner;
  logic       sample_strobe;
  logic       overrun;
  logic       fault;

  int n_pass = 0;
  int n_total = 0;
  int pos = 0;
  int amp_cnt = 0;
  int adc_cnt = 0;
  int dac_cnt = 0;
  int strobe_cnt = 0;
  int snap_a, snap_b, snap_c, snap_d;

  sample_sequencer #(
    .PERIOD_TICKS  (40),
    .TIMEOUT_TICKS (64),
    .CNT_W         (8)
  ) dut (
    .CLK_50M       (CLK_50M),
    .RESET         (RESET),
    .sck_tick      (sck_tick),
    .enable        (enable),
    .gain_req      (gain_req),
    .gain_value    (gain_value),
    .amp_done      (amp_done),
    .adc_done      (adc_done),
    .dac_done      (dac_done),
    .amp_start     (amp_start),
    .amp_gain      (amp_gain),
    .adc_start     (adc_start),
    .dac_start     (dac_start),
    .dac_sel       (dac_sel),
    .spi_owner     (spi_owner),
    .sample_strobe (sample_strobe),
    .overrun       (overrun),
    .fault         (fault)
  );

  always #10 CLK_50M = ~CLK_50M;

  // Pulse tallies sampled mid-cycle.
  always @(negedge CLK_50M) begin
    if (amp_start) amp_cnt++;
    if (adc_start) adc_cnt++;
    if (dac_start) dac_cnt++;
    if (sample_strobe) strobe_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic clk1();
    @(posedge CLK_50M);
    #1;
  endtask

  // One SCK rising edge: a one-cycle sck_tick followed by a quiet cycle.
  task automatic tick();
    sck_tick = 1'b1;
    clk1();
    sck_tick = 1'b0;
    clk1();
    pos = (pos + 1) % PERIOD;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_frame();
    ticks(PERIOD - pos);
  endtask

  task automatic greq(input logic [7:0] v);
    gain_value = v;
    gain_req = 1'b1;
    clk1();
    gain_req = 1'b0;
  endtask

  task automatic amp_pulse();
    amp_done = 1'b1;
    clk1();
    amp_done = 1'b0;
  endtask

  task automatic dac_pulse();
    dac_done = 1'b1;
    clk1();
    dac_done = 1'b0;
  endtask

  task automatic adc_pulse(input string tag);
    adc_done = 1'b1;
    #1;
    check(tag, int'(sample_strobe), 1);
    clk1();
    adc_done = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    #2 RESET = 1'b1;
    enable = 1'b1;
    repeat (3) clk1();
    check("rst_owner", int'(spi_owner), 0);
    check("rst_amp_gain", int'(amp_gain), 0);
    check("rst_starts", int'({amp_start, adc_start, dac_start, dac_sel}), 0);
    check("rst_flags", int'({overrun, fault, sample_strobe}), 0);
    RESET = 1'b0;
    clk1();
    pos = 0;

    // ---------------- nominal frame ----------------
    snap_a = adc_cnt;
    ticks(39);
    check("nom_no_early_adc", adc_cnt - snap_a, 0);
    tick();
    check("nom_adc_start", int'(adc_start), 1);
    check("nom_owner_adc", int'(spi_owner), 2);
    check("nom_no_amp", int'(amp_start), 0);
    clk1();
    check("nom_adc_start_1cyc", int'(adc_start), 0);
    ticks(10);
    adc_pulse("nom_strobe");
    check("nom_dac_a_start", int'(dac_start), 1);
    check("nom_dac_a_sel", int'(dac_sel), 0);
    check("nom_owner_dac", int'(spi_owner), 3);
    ticks(10);
    dac_pulse();
    check("nom_dac_b_start", int'(dac_start), 1);
    check("nom_dac_b_sel", int'(dac_sel), 1);
    ticks(10);
    dac_pulse();
    check("nom_owner_none", int'(spi_owner), 0);
    check("nom_no_flags", int'({overrun, fault}), 0);

    // ---------------- gain request ----------------
    greq(8'h11);
    check("gain_no_immediate_amp", int'(amp_start), 0);
    snap_a = amp_cnt;
    to_frame();
    check("gain_amp_start", int'(amp_start), 1);
    check("gain_amp_value", int'(amp_gain), 'h11);
    check("gain_owner_amp", int'(spi_owner), 1);
    check("gain_no_adc_yet", int'(adc_start), 0);
    clk1();
    check("gain_amp_1cyc", int'(amp_start), 0);
    ticks(5);
    greq(8'h11);
    greq(8'h22);
    amp_pulse();
    check("gain_adc_after_amp", int'(adc_start), 1);
    check("gain_owner_adc", int'(spi_owner), 2);
    check("gain_value_held", int'(amp_gain), 'h11);
    clk1();
    ticks(5);
    adc_pulse("gain_strobe");
    ticks(5);
    dac_pulse();
    ticks(5);
    dac_pulse();
    to_frame();
    check("gain_last_wins", int'(amp_gain), 'h22);
    check("gain_amp_start2", int'(amp_start), 1);
    clk1();
    amp_pulse();
    clk1();
    ticks(3);
    adc_pulse("gain_strobe2");
    ticks(3);
    dac_pulse();
    ticks(3);
    dac_pulse();
    check("gain_amp_count", amp_cnt - snap_a, 2);
    to_frame();
    check("gain_sent_once", int'(amp_start), 0);
    check("gain_plain_adc", int'(adc_start), 1);

    // ---------------- overrun ----------------
    clk1();
    ticks(5);
    adc_pulse("ovr_strobe");
    ticks(5);
    dac_pulse();
    snap_a = adc_cnt;
    to_frame();
    check("ovr_flag", int'(overrun), 1);
    check("ovr_no_restart", int'(adc_start), 0);
    check("ovr_owner_kept", int'(spi_owner), 3);
    ticks(5);
    dac_pulse();
    check("ovr_owner_none", int'(spi_owner), 0);
    to_frame();
    check("ovr_frame_skipped", adc_cnt - snap_a, 0);
    check("ovr_resume_adc", int'(adc_start), 1);
    check("ovr_sticky", int'(overrun), 1);

    // ---------------- stray done + timeout ----------------
    clk1();
    snap_b = dac_cnt;
    snap_c = strobe_cnt;
    dac_done = 1'b1;
    #1;
    check("stray_no_strobe", int'(sample_strobe), 0);
    clk1();
    dac_done = 1'b0;
    check("stray_no_dac_start", int'(dac_start), 0);
    check("stray_owner_adc", int'(spi_owner), 2);
    clk1();
    ticks(63);
    check("to_not_yet", int'(fault), 0);
    check("to_owner_before", int'(spi_owner), 2);
    tick();
    check("to_fault", int'(fault), 1);
    check("to_owner_none", int'(spi_owner), 0);
    check("to_no_dac", dac_cnt - snap_b, 0);
    check("to_no_strobe", strobe_cnt - snap_c, 0);
    to_frame();
    check("to_next_frame_adc", int'(adc_start), 1);
    check("to_fault_sticky", int'(fault), 1);
    clk1();
    ticks(4);
    adc_pulse("to_next_strobe");
    check("to_next_dac_a", int'(dac_start), 1);
    check("to_next_owner_dac", int'(spi_owner), 3);

    // ---------------- reset in DAC_A ----------------
    greq(8'h33);
    #3 RESET = 1'b1;
    #1;
    check("arst_owner", int'(spi_owner), 0);
    check("arst_amp_gain", int'(amp_gain), 0);
    check("arst_flags", int'({overrun, fault}), 0);
    check("arst_starts", int'({amp_start, adc_start, dac_start, dac_sel}), 0);
    clk1();
    clk1();
    RESET = 1'b0;
    pos = 0;
    snap_d = adc_cnt + amp_cnt;
    ticks(39);
    check("arst_no_early_start", adc_cnt + amp_cnt - snap_d, 0);
    check("arst_owner_idle", int'(spi_owner), 0);
    tick();
    check("arst_first_adc", int'(adc_start), 1);
    check("arst_pend_cleared", int'(amp_start), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
- Per-sample scheduler for the shared SPI bus between preamp (gain), ADC and dual-channel DAC.
- Generates the sampling-period tick and issues start pulses to the amp, ADC and DAC drivers in a fixed order.
- Owns the MOSI/CS ownership select and latches gain-change requests so they never collide with a conversion.
- Replaces ad-hoc MOSI muxing on AMP_CS with an explicit grant.

Parameters:
- PERIOD_TICKS, 40, sample period in SPI_SCK rising-edge ticks (≥ 8).
- TIMEOUT_TICKS, 64, maximum SCK ticks any driver may take before abort.
- CNT_W, 8, width of the period and timeout counters (must hold max(PERIOD_TICKS, TIMEOUT_TICKS)).

Ports:
- CLK_50M  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- sck_tick  in  1  one-CLK_50M-cycle pulse per SPI_SCK rising edge
- enable  in  1  0 = finish the current frame, then idle
- gain_req  in  1  one-cycle request to reprogram the preamp
- gain_value  in  8  gain code, captured when gain_req=1
- amp_done  in  1  pulse: preamp write finished
- adc_done  in  1  pulse: ADC frame (Va, Vb) valid
- dac_done  in  1  pulse: one DAC channel write finished
- amp_start  out  1  one-cycle start to preamp driver
- amp_gain  out  8  registered gain code presented to preamp driver
- adc_start  out  1  one-cycle start (AD_CONV request)
- dac_start  out  1  one-cycle start to DAC driver
- dac_sel  out  1  0 = channel A, 1 = channel B
- spi_owner  out  2  00 none, 01 amp, 10 adc, 11 dac (drives MOSI mux)
- sample_strobe  out  1  one-cycle pulse when adc_done is accepted (datapath latch enable)
- overrun  out  1  sticky: period expired with the frame incomplete
- fault  out  1  sticky: driver timeout

Behaviour:
- Reset: all outputs 0, amp_gain=0, FSM=IDLE, period counter=0, gain pending cleared.
- Period counter: advances on sck_tick, wraps at PERIOD_TICKS-1, then raises internal frame_tick for one cycle; it runs whenever enable=1.
- Gain capture: gain_req latches gain_value into a pending register and sets pend. A later request overwrites the value (last wins). Capture is allowed in any state.
- FSM transitions:
  - IDLE: on frame_tick & enable, go to AMP if pend, else ADC.
  - AMP: amp_gain<=pending, amp_start=1 for one cycle, spi_owner=01, pend cleared; go to AMP_W.
  - AMP_W: on amp_done, go to ADC.
  - ADC: adc_start=1, spi_owner=10; go to ADC_W.
  - ADC_W: on adc_done, sample_strobe=1 in the same cycle; go to DAC_A.
  - DAC_A: dac_sel=0, dac_start=1, spi_owner=11; go to DA_W.
  - DA_W: on dac_done, go to DAC_B.
  - DAC_B: dac_sel=1, dac_start=1; go to DB_W.
  - DB_W: on dac_done, go to IDLE, spi_owner=00.
- Start pulses are exactly one CLK_50M cycle. spi_owner changes only in start states and when returning to IDLE.
- Timeout: each *_W state counts sck_tick. On reaching TIMEOUT_TICKS, set fault, set spi_owner=00, and go to IDLE. The frame is dropped; the period counter is unaffected.
- Overrun: frame_tick outside IDLE sets overrun. The frame is skipped (no restart) and the current sequence continues.
- A done pulse arriving in a state that is not waiting for it is ignored.
- A gain_req in the same cycle AMP clears pend re-sets pend with the new value (the request is kept for the next frame).
- overrun and fault clear only on RESET.
- enable=0 mid-frame: the sequence completes, then the FSM stays in IDLE.
- RESET mid-frame: immediate return to reset values. Drivers see no further starts.

Decomposition:
- Shared package: state encoding constants, spi_owner codes (OWN_NONE/AMP/ADC/DAC), DAC channel codes.
- One natural sub-module: tick_counter (CNT_W, enable, tick-gated, wrap/terminal-count output), instanced twice: once for the period counter, once for the timeout counter (cleared on each state entry).

Test Plan:
- Nominal: PERIOD_TICKS=40, drivers answer done after 10 ticks, no gain_req → per frame: adc_start, then sample_strobe, then dac_start with sel 0, then sel 1. spi_owner sequence 10,11,00. No overrun/fault.
- Gain: gain_req with gain_value=0x11 mid-frame → next frame emits amp_start with amp_gain=0x11 before adc_start. Two requests 0x11 then 0x22 in one frame → only 0x22 is sent, once.
- Overrun: DAC done delayed so the frame takes 45 ticks with PERIOD=40 → overrun=1 at tick 40, the next frame is skipped, and sequencing resumes at the following frame_tick.
- Timeout: adc_done never asserted → fault=1 after 64 ticks, spi_owner=00, no dac_start. The next frame runs normally.
- Reset mid-DAC_A: assert RESET while owner=11 → all outputs 0 asynchronously. After release, the first start occurs only after a full period.
- Stray done: dac_done pulsed in ADC_W → ignored, state unchanged, and sample_strobe only appears on adc_done.
